// File: rtl/clk_div_multi_if.sv
// -----------------------------------------------------------------------------
// clk_div_multi_if
// Bundles the control inputs and generated outputs of the multi-channel clock
// generator so the command side and the generator share a single port.
//
//   EN        per-channel run enable (level)
//   LOAD      per-channel one-cycle strobe capturing HI_CNT/LO_CNT into shadow
//   HI_CNT    packed high-phase lengths, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   LO_CNT    packed low-phase lengths, same slicing
//   SYNC      one-cycle strobe restarting all enabled channels in phase
//   CLK_OUT   generated clocks
//   TC_PULSE  one-cycle pulse on each CLK_OUT rising edge
//   PENDING   shadow loaded but not yet applied
//
// master : command side (drives controls, observes outputs)
// slave  : generator side
// -----------------------------------------------------------------------------
interface clk_div_multi_if #(
   parameter int NUM_CH    = 4,
   parameter int DIV_WIDTH = 16
);
   logic [NUM_CH-1:0]           EN;
   logic [NUM_CH-1:0]           LOAD;
   logic [NUM_CH*DIV_WIDTH-1:0] HI_CNT;
   logic [NUM_CH*DIV_WIDTH-1:0] LO_CNT;
   logic                        SYNC;
   logic [NUM_CH-1:0]           CLK_OUT;
   logic [NUM_CH-1:0]           TC_PULSE;
   logic [NUM_CH-1:0]           PENDING;

   modport master (
      output EN, LOAD, HI_CNT, LO_CNT, SYNC,
      input  CLK_OUT, TC_PULSE, PENDING
   );

   modport slave (
      input  EN, LOAD, HI_CNT, LO_CNT, SYNC,
      output CLK_OUT, TC_PULSE, PENDING
   );
endinterface

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel programmable clock generator. Each channel produces a clock
// with independent high/low phase lengths, a double-buffered divisor that is
// only applied when the output rises (so no runt pulses), and a shared SYNC
// that restarts every enabled channel in phase. All outputs are registered in
// the CLK_IN domain.
//
// Ports:
//   CLK_IN   system clock, rising edge
//   RST_N    asynchronous active-low reset
//   bus      clk_div_multi_if.slave (EN, LOAD, HI_CNT, LO_CNT, SYNC in;
//            CLK_OUT, TC_PULSE, PENDING out)
// -----------------------------------------------------------------------------
module clk_div_multi #(
   parameter int NUM_CH    = 4,
   parameter int DIV_WIDTH = 16
) (
   input  logic            CLK_IN,
   input  logic            RST_N,
   clk_div_multi_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam logic [DIV_WIDTH-1:0] ONE_C  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DIV_WIDTH-1:0] ZERO_C = {DIV_WIDTH{1'b0}};

   // A programmed length of zero behaves as a single cycle.
   function automatic logic [DIV_WIDTH-1:0] clamp_len(input logic [DIV_WIDTH-1:0] len);
      return (len == ZERO_C) ? ONE_C : len;
   endfunction

   logic [NUM_CH-1:0] clk_out_s;
   logic [NUM_CH-1:0] tc_pulse_s;
   logic [NUM_CH-1:0] pending_s;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      state_t                 state_r;
      logic [DIV_WIDTH-1:0]   cntr_r;
      logic [DIV_WIDTH-1:0]   hi_act_r;
      logic [DIV_WIDTH-1:0]   lo_act_r;
      logic [DIV_WIDTH-1:0]   hi_shd_r;
      logic [DIV_WIDTH-1:0]   lo_shd_r;
      logic                   pend_r;
      logic                   clk_r;
      logic                   tc_r;
      logic [DIV_WIDTH-1:0]   hi_in_s;
      logic [DIV_WIDTH-1:0]   lo_in_s;
      logic                   start_s;

      // Decode this channel's length slices and whether the output rises on
      // the coming edge (the single apply point for the shadow registers).
      always_comb begin
         hi_in_s = clamp_len(bus.HI_CNT[ch*DIV_WIDTH +: DIV_WIDTH]);
         lo_in_s = clamp_len(bus.LO_CNT[ch*DIV_WIDTH +: DIV_WIDTH]);
         start_s = 1'b0;
         if (bus.SYNC && bus.EN[ch]) begin
            start_s = 1'b1;
         end else begin
            case (state_r)
               ST_IDLE: start_s = bus.EN[ch];
               ST_LOW:  start_s = (cntr_r >= lo_act_r) && bus.EN[ch];
               default: start_s = 1'b0;
            endcase
         end
      end

      // Per-channel phase FSM, counter, and double-buffered divisor.
      always_ff @(posedge CLK_IN or negedge RST_N) begin
         if (!RST_N) begin
            state_r  <= ST_IDLE;
            cntr_r   <= ONE_C;
            hi_act_r <= ONE_C;
            lo_act_r <= ONE_C;
            hi_shd_r <= ONE_C;
            lo_shd_r <= ONE_C;
            pend_r   <= 1'b0;
            clk_r    <= 1'b0;
            tc_r     <= 1'b0;
         end else begin
            tc_r <= 1'b0;
            if (start_s) begin
               // Entering HIGH; the shadow present before this edge is
               // what gets applied, a LOAD on this same edge waits.
               state_r <= ST_HIGH;
               clk_r   <= 1'b1;
               tc_r    <= 1'b1;
               cntr_r  <= ONE_C;
               if (pend_r) begin
                  hi_act_r <= hi_shd_r;
                  lo_act_r <= lo_shd_r;
               end
            end else begin
               case (state_r)
                  ST_IDLE: begin
                     clk_r  <= 1'b0;
                     cntr_r <= ONE_C;
                  end
                  ST_HIGH: begin
                     if (cntr_r >= hi_act_r) begin
                        state_r <= ST_LOW;
                        clk_r   <= 1'b0;
                        cntr_r  <= ONE_C;
                     end else begin
                        cntr_r  <= cntr_r + ONE_C;
                     end
                  end
                  ST_LOW: begin
                     // Reaching the end of LOW without start_s means EN is low.
                     if (cntr_r >= lo_act_r) begin
                        state_r <= ST_IDLE;
                        clk_r   <= 1'b0;
                        cntr_r  <= ONE_C;
                     end else begin
                        cntr_r  <= cntr_r + ONE_C;
                     end
                  end
                  default: begin
                     state_r <= ST_IDLE;
                     clk_r   <= 1'b0;
                     cntr_r  <= ONE_C;
                  end
               endcase
            end

            if (bus.LOAD[ch]) begin
               hi_shd_r <= hi_in_s;
               lo_shd_r <= lo_in_s;
               pend_r   <= 1'b1;
            end else if (start_s) begin
               pend_r   <= 1'b0;
            end else begin
               pend_r   <= pend_r;
            end
         end
      end

      assign clk_out_s[ch]  = clk_r;
      assign tc_pulse_s[ch] = tc_r;
      assign pending_s[ch]  = pend_r;
   end

   assign bus.CLK_OUT  = clk_out_s;
   assign bus.TC_PULSE = tc_pulse_s;
   assign bus.PENDING  = pending_s;

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Directed bench for clk_div_multi: reset state, duty-cycle programming,
// boundary-only divisor update, zero and maximum lengths, SYNC alignment,
// graceful disable, and asynchronous reset mid-period.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;
   localparam int NUM_CH = 4;
   localparam int DW     = 16;

   logic CLK_IN = 1'b0;
   logic RST_N  = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   hcnt;

   clk_div_multi_if #(.NUM_CH(NUM_CH), .DIV_WIDTH(DW)) bus ();

   clk_div_multi #(.NUM_CH(NUM_CH), .DIV_WIDTH(DW)) dut (
      .CLK_IN (CLK_IN),
      .RST_N  (RST_N),
      .bus    (bus)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic tick();
      @(posedge CLK_IN);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
      bus.HI_CNT[ch*DW +: DW] = hi;
      bus.LO_CNT[ch*DW +: DW] = lo;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.EN     = 4'b0000;
      bus.LOAD   = 4'b0000;
      bus.HI_CNT = '0;
      bus.LO_CNT = '0;
      bus.SYNC   = 1'b0;

      // Reset state
      #1 RST_N = 1'b0;
      #2;
      check("rst_clk", bus.CLK_OUT, 4'b0000);
      check("rst_tc", bus.TC_PULSE, 4'b0000);
      check("rst_pend", bus.PENDING, 4'b0000);
      tick();
      tick();
      RST_N = 1'b1;
      tick();

      // ch0 3/2
      set_ch(0, 16'd3, 16'd2);
      bus.LOAD = 4'b0001;
      tick();
      bus.LOAD = 4'b0000;
      check("t1_pend_set", bus.PENDING, 4'b0001);
      check("t1_idle_low", bus.CLK_OUT, 4'b0000);
      bus.EN = 4'b0001;
      tick();
      check("t1_start_clk", bus.CLK_OUT, 4'b0001);
      check("t1_start_tc", bus.TC_PULSE, 4'b0001);
      check("t1_start_pend", bus.PENDING, 4'b0000);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("t1_clk0", bus.CLK_OUT[0], (k % 5) < 3);
         check("t1_tc0", bus.TC_PULSE[0], (k % 5) == 0);
      end

      // ch1 4/4, reload 1/1 mid-high
      set_ch(1, 16'd4, 16'd4);
      bus.LOAD = 4'b0010;
      tick();
      bus.LOAD = 4'b0000;
      check("t2_pend_set", bus.PENDING[1], 1'b1);
      bus.EN = 4'b0011;
      tick();
      check("t2_start_clk1", bus.CLK_OUT[1], 1'b1);
      check("t2_start_tc1", bus.TC_PULSE[1], 1'b1);
      check("t2_start_pend1", bus.PENDING[1], 1'b0);
      tick();
      set_ch(1, 16'd1, 16'd1);
      bus.LOAD = 4'b0010;
      tick();
      bus.LOAD = 4'b0000;
      check("t2_reload_pend1", bus.PENDING[1], 1'b1);
      for (int k = 3; k <= 11; k++) begin
         tick();
         check("t2_clk1", bus.CLK_OUT[1], (k < 4) ? 1'b1 : (k < 8) ? 1'b0 : ((k - 8) % 2 == 0));
         check("t2_tc1", bus.TC_PULSE[1], (k == 8) || (k == 10));
         check("t2_pend1", bus.PENDING[1], k < 8);
      end

      // SYNC: ch0 2/3, ch1 5/1, ch2/ch3 disabled
      set_ch(0, 16'd2, 16'd3);
      set_ch(1, 16'd5, 16'd1);
      bus.LOAD = 4'b0011;
      tick();
      bus.LOAD = 4'b0000;
      tick();
      tick();
      bus.SYNC = 1'b1;
      tick();
      bus.SYNC = 1'b0;
      check("t4_sync_clk", bus.CLK_OUT, 4'b0011);
      check("t4_sync_tc", bus.TC_PULSE, 4'b0011);
      check("t4_sync_pend", bus.PENDING, 4'b0000);
      for (int k = 1; k <= 6; k++) begin
         tick();
         check("t4_clk", bus.CLK_OUT, {2'b00, (k % 6) < 5, (k % 5) < 2});
         check("t4_tc", bus.TC_PULSE, {2'b00, (k % 6) == 0, (k % 5) == 0});
      end

      // EN0 dropped mid-high of a 3/2 period
      set_ch(0, 16'd3, 16'd2);
      bus.LOAD = 4'b0001;
      tick();
      bus.LOAD = 4'b0000;
      bus.SYNC = 1'b1;
      tick();
      bus.SYNC = 1'b0;
      check("t5_sync_clk0", bus.CLK_OUT[0], 1'b1);
      check("t5_sync_tc0", bus.TC_PULSE[0], 1'b1);
      tick();
      bus.EN = 4'b0010;
      for (int k = 2; k <= 8; k++) begin
         tick();
         check("t5_clk0", bus.CLK_OUT[0], k < 3);
         check("t5_tc0", bus.TC_PULSE[0], 1'b0);
      end
      bus.EN = 4'b0011;
      tick();
      check("t5_restart_clk0", bus.CLK_OUT[0], 1'b1);
      check("t5_restart_tc0", bus.TC_PULSE[0], 1'b1);

      // ch2 zero lengths, then maximum high phase
      set_ch(2, 16'd0, 16'd0);
      bus.LOAD = 4'b0100;
      tick();
      bus.LOAD = 4'b0000;
      bus.EN = 4'b0111;
      tick();
      check("t3_start_clk2", bus.CLK_OUT[2], 1'b1);
      check("t3_start_tc2", bus.TC_PULSE[2], 1'b1);
      check("t3_start_pend2", bus.PENDING[2], 1'b0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("t3_zero_clk2", bus.CLK_OUT[2], (k % 2) == 0);
      end
      set_ch(2, 16'hFFFF, 16'd1);
      bus.LOAD = 4'b0100;
      tick();
      bus.LOAD = 4'b0000;
      check("t3_same_edge_clk2", bus.CLK_OUT[2], 1'b1);
      check("t3_same_edge_pend2", bus.PENDING[2], 1'b1);
      tick();
      check("t3_old_applied_clk2", bus.CLK_OUT[2], 1'b0);
      tick();
      check("t3_max_rise_clk2", bus.CLK_OUT[2], 1'b1);
      check("t3_max_rise_tc2", bus.TC_PULSE[2], 1'b1);
      check("t3_max_rise_pend2", bus.PENDING[2], 1'b0);
      hcnt = 1;
      for (int g = 0; g < 70000; g++) begin
         tick();
         if (bus.CLK_OUT[2]) begin
            hcnt++;
         end else begin
            break;
         end
      end
      check("t3_max_high_len", hcnt, 32'd65535);
      tick();
      check("t3_after_low_clk2", bus.CLK_OUT[2], 1'b1);
      check("t3_after_low_tc2", bus.TC_PULSE[2], 1'b1);

      // Asynchronous reset mid-high
      set_ch(3, 16'd7, 16'd7);
      bus.LOAD = 4'b1000;
      tick();
      bus.LOAD = 4'b0000;
      check("t6_pre_pend3", bus.PENDING[3], 1'b1);
      check("t6_pre_clk2", bus.CLK_OUT[2], 1'b1);
      #3 RST_N = 1'b0;
      #1;
      check("t6_async_clk", bus.CLK_OUT, 4'b0000);
      check("t6_async_tc", bus.TC_PULSE, 4'b0000);
      check("t6_async_pend", bus.PENDING, 4'b0000);
      bus.EN = 4'b0001;
      #1 RST_N = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         tick();
         check("t6_dflt_clk", bus.CLK_OUT, (k % 2 == 0) ? 4'b0001 : 4'b0000);
         check("t6_dflt_tc", bus.TC_PULSE, (k % 2 == 0) ? 4'b0001 : 4'b0000);
         check("t6_dflt_pend", bus.PENDING, 4'b0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
